// File: rtl/regfile_mp.sv
// regfile_mp: two-write, NUM_RD-read register file with write bypass,
// optional registered reads and a per-entry busy scoreboard.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int RD_LAT   = 0
) (
    input  logic                       clk,
    input  logic                       reset_b,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic [1:0]                 wr_en,
    input  logic [2*ADDR_W-1:0]        wr_addr,
    input  logic [2*DATA_W-1:0]        wr_data,
    input  logic                       rsv_en,
    input  logic [ADDR_W-1:0]          rsv_addr,
    output logic [2**ADDR_W-1:0]       busy_vec
);
    localparam int DEPTH = 2**ADDR_W;

    if (NUM_RD < 1 || NUM_RD > 4 || RD_LAT > 1 || RD_LAT < 0) begin : g_bad
        $error("regfile_mp: NUM_RD must be 1..4 and RD_LAT 0..1");
    end

    logic [DATA_W-1:0]        mem [DEPTH];
    logic [DEPTH-1:0]         busy;
    logic [ADDR_W-1:0]        wa [2];
    logic [DATA_W-1:0]        wd [2];
    logic [1:0]               we;
    logic                     re;
    logic [NUM_RD*DATA_W-1:0] rd_c;
    logic [NUM_RD-1:0]        busy_c;

    // writes and reservations aimed at a hardwired-zero entry are squashed here
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            wa[k] = wr_addr[k*ADDR_W +: ADDR_W];
            wd[k] = wr_data[k*DATA_W +: DATA_W];
            we[k] = wr_en[k] && !(ZERO_REG != 0 && wa[k] == '0);
        end
        re = rsv_en && !(ZERO_REG != 0 && rsv_addr == '0);
    end

    always_ff @(posedge clk) begin
        if (reset_b) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            busy <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (we[k]) begin
                    mem[wa[k]]  <= wd[k];
                    busy[wa[k]] <= 1'b0;
                end
            end
            if (re) busy[rsv_addr] <= 1'b1;
        end
    end

    assign busy_vec = busy;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic [1:0]        hit;
        logic              rhit;
        assign a    = rd_addr[i*ADDR_W +: ADDR_W];
        assign hit  = (BYPASS != 0) ? (we & {wa[1] == a, wa[0] == a}) : 2'b00;
        assign rhit = re && rsv_addr == a;
        assign rd_c[i*DATA_W +: DATA_W] = hit[1] ? wd[1] : hit[0] ? wd[0] :
                                          (ZERO_REG != 0 && a == '0) ? '0 : mem[a];
        // registered reads with bypass present the post-edge scoreboard state
        assign busy_c[i] = (|hit) ? rhit :
                           (RD_LAT != 0 && BYPASS != 0 && rhit) ? 1'b1 : busy[a];
    end

    if (RD_LAT == 0) begin : g_comb
        assign rd_data = rd_c;
        assign rd_busy = busy_c;
    end else begin : g_reg
        always_ff @(posedge clk) begin
            if (reset_b) begin
                rd_data <= '0;
                rd_busy <= '0;
            end else begin
                rd_data <= rd_c;
                rd_busy <= busy_c;
            end
        end
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed checks of regfile_mp in default, no-zero/no-bypass
// and registered-read builds driven by shared stimulus.
module tb_regfile_mp;
    logic        clk = 1'b0;
    logic        reset_b;
    logic [9:0]  rd_addr;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic [63:0] m_rd, a_rd, l_rd;
    logic [1:0]  m_busy, a_busy, l_busy;
    logic [31:0] m_vec, a_vec, l_vec;
    logic [31:0] mm [32];
    logic [31:0] bm;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    regfile_mp u_main (
        .clk(clk), .reset_b(reset_b), .rd_addr(rd_addr), .rd_data(m_rd), .rd_busy(m_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en),
        .rsv_addr(rsv_addr), .busy_vec(m_vec)
    );

    regfile_mp #(.ZERO_REG(0), .BYPASS(0)) u_alt (
        .clk(clk), .reset_b(reset_b), .rd_addr(rd_addr), .rd_data(a_rd), .rd_busy(a_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en),
        .rsv_addr(rsv_addr), .busy_vec(a_vec)
    );

    regfile_mp #(.RD_LAT(1)) u_lat (
        .clk(clk), .reset_b(reset_b), .rd_addr(rd_addr), .rd_data(l_rd), .rd_busy(l_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en),
        .rsv_addr(rsv_addr), .busy_vec(l_vec)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        reset_b = 1'b0;
        wr_en   = 2'b00;
        rsv_en  = 1'b0;
    endtask

    task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
        wr_en[p]           = 1'b1;
        wr_addr[p*5 +: 5]  = a;
        wr_data[p*32 +: 32] = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0] a;
        rd_addr = '0; wr_addr = '0; wr_data = '0; rsv_addr = '0;
        idle();
        reset_b = 1'b1;
        tick(); tick();
        idle();

        // reset clears contents and overrides a same-cycle write/reserve
        for (int e = 1; e < 32; e++) begin
            idle(); wr(0, 5'(e), 32'hDEADBEEF); tick();
        end
        idle(); rd_addr = {5'd31, 5'd5}; #1;
        check("pre_rst_rd0", m_rd[31:0], 64'hDEADBEEF);
        check("pre_rst_rd1", m_rd[63:32], 64'hDEADBEEF);
        reset_b = 1'b1; wr(0, 5'd5, 32'h77); rsv_en = 1'b1; rsv_addr = 5'd3;
        tick(); idle(); #1;
        check("rst_rd", m_rd, 64'h0);
        check("rst_vec", m_vec, 64'h0);
        check("rst_lat_rd", l_rd, 64'h0);
        check("rst_alt_rd", a_rd, 64'h0);

        // dual write, then same-address collision
        wr(0, 5'd5, 32'd10); wr(1, 5'd6, 32'd20); tick(); idle();
        rd_addr = {5'd6, 5'd5}; #1;
        check("dual_rd5", m_rd[31:0], 64'd10);
        check("dual_rd6", m_rd[63:32], 64'd20);
        wr(0, 5'd5, 32'd10); wr(1, 5'd5, 32'd30); #1;
        check("byp_pri", m_rd[31:0], 64'd30);
        tick(); idle(); #1;
        check("wr_pri", m_rd[31:0], 64'd30);
        check("lat_byp", l_rd[31:0], 64'd30);

        // hardwired zero entry
        wr(0, 5'd0, 32'h1234); rsv_en = 1'b1; rsv_addr = 5'd0; rd_addr = {5'd6, 5'd0}; #1;
        check("zr_byp", m_rd[31:0], 64'h0);
        tick(); idle(); #1;
        check("zr_rd", m_rd[31:0], 64'h0);
        check("zr_busy", 64'(m_vec[0]), 64'h0);
        check("nz_rd", a_rd[31:0], 64'h1234);
        check("nz_busy", 64'(a_vec[0]), 64'h1);

        // same-cycle bypass versus old value
        rd_addr = {5'd6, 5'd7}; wr(0, 5'd7, 32'h55); #1;
        check("byp", m_rd[31:0], 64'h55);
        check("nobyp", a_rd[31:0], 64'h0);
        tick(); idle(); #1;
        check("nobyp_next", a_rd[31:0], 64'h55);

        // scoreboard
        rsv_en = 1'b1; rsv_addr = 5'd9; rd_addr = {5'd6, 5'd9}; #1;
        check("rsv_comb", 64'(m_busy), 64'h0);
        tick(); idle(); #1;
        check("rsv_vec", 64'(m_vec[9]), 64'h1);
        check("rsv_rdbusy", 64'(m_busy), 64'h1);
        wr(0, 5'd9, 32'hA); #1;
        check("clr_byp", 64'(m_busy), 64'h0);
        tick(); idle(); #1;
        check("clr_vec", 64'(m_vec[9]), 64'h0);
        rsv_en = 1'b1; rsv_addr = 5'd9; wr(1, 5'd9, 32'hB);
        tick(); idle(); #1;
        check("rsv_wins", 64'(m_vec[9]), 64'h1);
        check("rsv_wins_rd", m_rd[31:0], 64'hB);

        // registered-read sweep against a model, reset in the middle
        reset_b = 1'b1; tick(); idle();
        for (int j = 0; j < 32; j++) mm[j] = '0;
        bm = '0;
        for (int i = 0; i < 32; i++) begin
            idle();
            rd_addr  = {5'(31 - i), 5'(i)};
            wr_en    = 2'($urandom);
            wr_addr  = 10'($urandom);
            wr_data  = {$urandom, $urandom};
            rsv_en   = 1'($urandom);
            rsv_addr = 5'($urandom);
            reset_b  = (i == 16);
            if (reset_b) begin
                for (int j = 0; j < 32; j++) mm[j] = '0;
                bm = '0;
            end else begin
                for (int k = 0; k < 2; k++) begin
                    a = wr_addr[k*5 +: 5];
                    if (wr_en[k] && a != 5'd0) begin
                        mm[a] = wr_data[k*32 +: 32];
                        bm[a] = 1'b0;
                    end
                end
                if (rsv_en && rsv_addr != 5'd0) bm[rsv_addr] = 1'b1;
            end
            tick();
            check("sweep_rd0", l_rd[31:0], 64'(mm[5'(i)]));
            check("sweep_rd1", l_rd[63:32], 64'(mm[5'(31 - i)]));
            check("sweep_busy", 64'(l_busy), 64'({bm[5'(31 - i)], bm[5'(i)]}));
        end
        idle(); tick();
        check("sweep_vec", 64'(l_vec), 64'(bm));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
